parallel_master: RTL and testbench
==================================

Name: parallel_master

Overview:
Initiator end of the 3-phase parallel accelerometer bus: strobe line, chip-select line and 8 bidirectional data pins.
- Per request, issues one frame on the bus:
  - command byte 'x'/'y'/'z' (120/121/122);
  - two read strobes returning the low then the high byte.
- Results are presented as one 16-bit word.
- Used on a second board or in the loopback harness to drive the responder at the FPGA end.
- Clocked from CLK_50; the bus strobe is derived by an internal phase counter.

Parameters:
HALF_CYCLES, 25, CLK_50 cycles per bus-strobe half period (25 gives a 1 MHz strobe); legal minimum 3.
CMD_BASE, 120, command byte for axis 0; axis n sends CMD_BASE+n.

Ports:
CLK_50  in  1  system clock, 50 MHz
rst  in  1  synchronous active-high reset
start  in  1  request pulse; sampled only in IDLE
axis  in  2  0=x, 1=y, 2=z; 3 illegal
busy  out  1  high from the cycle after start is accepted until DONE completes
done  out  1  one-cycle pulse; result valid
err  out  1  one-cycle pulse; start with axis==3 rejected
result  out  16  {high byte, low byte} of the last completed frame
bus_clk  out  1  strobe to responder; responder acts on its rising edge
bus_cs  out  1  chip select, active high, framing the whole transaction
bus_dout  out  8  data driven to the pins
bus_oe  out  1  pin output enable (tristate control)
bus_din  in  8  pin readback; asynchronous to CLK_50

Behaviour:
- Reset values:
  - busy, done, err, bus_clk, bus_cs, bus_oe = 0;
  - bus_dout = 0, result = 0;
  - FSM = IDLE, phase counter = 0.
- bus_din passes through a 2-flop synchronizer before any use. This is why HALF_CYCLES must be at least 3.
- Phase counter:
  - counts 0..HALF_CYCLES-1 in every state except IDLE and DONE;
  - the state advances when the count reaches HALF_CYCLES-1;
  - the counter then reloads to 0.
- States and outputs:
  - IDLE: all bus outputs at reset values.
    - start & axis<3: latch axis, load bus_dout=CMD_BASE+axis, go SETUP.
    - start & axis==3: err=1 for one cycle, stay IDLE.
  - SETUP: bus_cs=1, bus_oe=1, bus_clk=0.
  - CMD_HI: bus_clk=1, command held (1st rising edge: responder latches command).
  - TURN: bus_clk=0, bus_oe=0, bus_dout=0.
  - LO_HI: bus_clk=1 (2nd rising edge: responder presents low byte). On the last count, capture synchronized bus_din into lo_reg.
  - LO_LO: bus_clk=0.
  - HI_HI: bus_clk=1 (3rd rising edge). On the last count, capture into hi_reg.
  - HOLD: bus_clk=0, bus_cs=1.
  - DONE (1 cycle): bus_cs=0, result={hi_reg,lo_reg}, done=1, then IDLE.
- Latency: start accepted in cycle 0 → done high in cycle 7*HALF_CYCLES+1.
- Exactly 3 rising bus_clk edges per frame. bus_oe never overlaps a responder-driven phase: it is 0 from TURN onward.
- result changes only in DONE. Low and high bytes update together, never a torn word.
- Start while busy: ignored, with no queueing and no err.
- Reset mid-frame: returns to IDLE on the next edge, with bus_clk=0 and bus_cs=0 immediately.
  - Strobe edges already issued are not undone, so the responder's byte counter may desync.
  - The system recovers by issuing a full frame afterward; this is documented, not corrected.
- start asserted in the same cycle as rst: rst wins.

Decomposition:
- Package parallel_pkg holds:
  - command constants CMD_X=120, CMD_Y=121, CMD_Z=122;
  - state enum: IDLE, SETUP, CMD_HI, TURN, LO_HI, LO_LO, HI_HI, HOLD, DONE;
  - axis code localparams.
- One sub-module, parallel_phase_timer: a HALF_CYCLES-parameterized counter with a terminal-count output and synchronous clear.

Test Plan:
- HALF_CYCLES=4, axis=1 start; responder model returns 0x34 then 0x12 → bus_dout=121 while bus_oe=1; 3 bus_clk rising edges; done at cycle 29; result=0x1234.
- axis=3 start → err pulse the next cycle; bus_cs, bus_clk, bus_oe stay 0; result unchanged.
- start re-asserted every cycle during a frame (axis=0) → single frame only; a second frame starts only when start is asserted after done.
- rst asserted at cycle 10 of a frame → the next cycle has all outputs at reset values and result=0; a following axis=2 frame returns the model's bytes correctly.
- Back-to-back frames x then z; model returns 0x00FF then 0x8001 → result=0x00FF, then 0x8001; done spacing ≥ 7*HALF_CYCLES+2.
- Bus-conflict check across all frames: bus_oe=1 never coincides with the model driving the pins.

Source files
------------

// File: rtl/parallel_pkg.sv
// parallel_pkg: shared command bytes, axis codes and frame state encoding
package parallel_pkg;

    localparam logic [7:0] CMD_X = 8'd120;
    localparam logic [7:0] CMD_Y = 8'd121;
    localparam logic [7:0] CMD_Z = 8'd122;

    localparam logic [1:0] AXIS_X   = 2'd0;
    localparam logic [1:0] AXIS_Y   = 2'd1;
    localparam logic [1:0] AXIS_Z   = 2'd2;
    localparam logic [1:0] AXIS_BAD = 2'd3;

    // Frame states run in declaration order; the FSM steps by +1 between IDLE and DONE.
    typedef enum logic [3:0] {
        IDLE, SETUP, CMD_HI, TURN, LO_HI, LO_LO, HI_HI, HOLD, DONE
    } state_t;

endpackage

// File: rtl/parallel_phase_timer.sv
// parallel_phase_timer: counts 0..HALF_CYCLES-1 while enabled, flags the last count
module parallel_phase_timer #(
    parameter int HALF_CYCLES = 25
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam int W = $clog2(HALF_CYCLES);
    localparam logic [W-1:0] LAST = W'(HALF_CYCLES - 1);

    logic [W-1:0] r_cnt;

    assign o_tc = i_en && r_cnt == LAST;

    always_ff @(posedge clk) begin
        if (rst || i_clr || o_tc)
            r_cnt <= '0;
        else if (i_en)
            r_cnt <= r_cnt + 1'b1;
    end

endmodule

// File: rtl/parallel_master.sv
// parallel_master: initiator of the 3-phase parallel accelerometer bus
// One request sends a command byte, then reads the low and high data bytes.
module parallel_master
    import parallel_pkg::*;
#(
    parameter int HALF_CYCLES = 25,
    parameter int CMD_BASE    = int'(CMD_X)
) (
    input  logic        CLK_50,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  axis,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] result,
    output logic        bus_clk,
    output logic        bus_cs,
    output logic [7:0]  bus_dout,
    output logic        bus_oe,
    input  logic [7:0]  bus_din
);

    state_t      r_state, w_next;
    logic [1:0]  r_axis, w_axis;
    logic [7:0]  r_din1, r_din2, r_lo, r_hi;
    logic        w_run, w_tc, w_accept, w_reject;
    logic        w_clk, w_cs, w_oe;
    logic [7:0]  w_dout;

    assign w_run = r_state != IDLE && r_state != DONE;

    parallel_phase_timer #(.HALF_CYCLES(HALF_CYCLES)) u_timer (
        .clk  (CLK_50),
        .rst  (rst),
        .i_clr(!w_run),
        .i_en (w_run),
        .o_tc (w_tc)
    );

    always_comb begin
        w_accept = r_state == IDLE && start && axis != AXIS_BAD;
        w_reject = r_state == IDLE && start && axis == AXIS_BAD;
        w_next   = r_state;
        if (w_accept)
            w_next = SETUP;
        else if (r_state == DONE)
            w_next = IDLE;
        else if (w_run && w_tc)
            w_next = state_t'(4'(r_state) + 4'd1);
        // Bus pins are registered from the next state so the strobe never glitches.
        w_axis = w_accept ? axis : r_axis;
        w_clk  = w_next inside {CMD_HI, LO_HI, HI_HI};
        w_cs   = w_next != IDLE && w_next != DONE;
        w_oe   = w_next inside {SETUP, CMD_HI};
        w_dout = w_oe ? 8'(CMD_BASE + int'(w_axis)) : 8'd0;
    end

    always_ff @(posedge CLK_50) begin
        if (rst) begin
            r_state  <= IDLE;
            r_axis   <= '0;
            r_din1   <= '0;
            r_din2   <= '0;
            r_lo     <= '0;
            r_hi     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            result   <= '0;
            bus_clk  <= 1'b0;
            bus_cs   <= 1'b0;
            bus_oe   <= 1'b0;
            bus_dout <= '0;
        end else begin
            r_state  <= w_next;
            r_axis   <= w_axis;
            r_din1   <= bus_din;
            r_din2   <= r_din1;
            busy     <= w_next != IDLE;
            done     <= w_next == DONE;
            err      <= w_reject;
            bus_clk  <= w_clk;
            bus_cs   <= w_cs;
            bus_oe   <= w_oe;
            bus_dout <= w_dout;
            if (r_state == LO_HI && w_tc)
                r_lo <= r_din2;
            if (r_state == HI_HI && w_tc)
                r_hi <= r_din2;
            if (r_state == HOLD && w_tc)
                result <= {r_hi, r_lo};
        end
    end

endmodule

// File: tb/tb_parallel_master.sv
// tb_parallel_master: directed frames against a cycle-level frame model and a responder
module tb_parallel_master;

    localparam int H    = 4;
    localparam int CMDB = 120;
    localparam int LAT  = 7 * H + 1;

    logic        CLK_50 = 1'b0;
    logic        rst, start;
    logic [1:0]  axis;
    logic        busy, done, err, bus_clk, bus_cs, bus_oe;
    logic [15:0] result;
    logic [7:0]  bus_dout;
    logic [7:0]  bus_din = 8'd0;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    logic [7:0] lo_b, hi_b;

    parallel_master #(.HALF_CYCLES(H), .CMD_BASE(CMDB)) dut (
        .CLK_50  (CLK_50),
        .rst     (rst),
        .start   (start),
        .axis    (axis),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .result  (result),
        .bus_clk (bus_clk),
        .bus_cs  (bus_cs),
        .bus_dout(bus_dout),
        .bus_oe  (bus_oe),
        .bus_din (bus_din)
    );

    always #10 CLK_50 = ~CLK_50;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Frame model: a frame occupies the LAT cycles after acceptance.
    int          cyc = 0;
    bit          m_active = 1'b0;
    int          m_t0 = 0;
    int          m_err_at = -1;
    logic [1:0]  m_axis = 2'd0;
    logic [15:0] m_pend = 16'd0;
    logic [15:0] m_result = 16'd0;

    always @(posedge CLK_50) begin
        if (rst) begin
            m_active <= 1'b0;
            m_result <= 16'd0;
            m_err_at <= -1;
        end else if (m_active) begin
            if (cyc == m_t0 + LAT) begin
                m_active <= 1'b0;
                m_result <= m_pend;
            end
        end else if (start) begin
            if (axis == 2'd3)
                m_err_at <= cyc + 1;
            else begin
                m_active <= 1'b1;
                m_t0     <= cyc;
                m_axis   <= axis;
                m_pend   <= {hi_b, lo_b};
            end
        end
        cyc <= cyc + 1;
    end

    // Responder: sees the strobe one CLK_50 late, then drives the next byte.
    logic prev_clk = 1'b0;
    logic rsp_drv = 1'b0;
    int   rsp_cnt = 0;
    int   n_rise = 0;
    logic [7:0] rsp_cmd = 8'd0;

    always @(posedge CLK_50) begin
        prev_clk <= bus_clk;
        if (!bus_cs) begin
            rsp_cnt <= 0;
            rsp_drv <= 1'b0;
            bus_din <= 8'd0;
        end else if (bus_clk && !prev_clk) begin
            rsp_cnt <= rsp_cnt + 1;
            n_rise  <= n_rise + 1;
            if (rsp_cnt == 0)
                rsp_cmd <= bus_dout;
            else if (rsp_cnt == 1) begin
                bus_din <= lo_b;
                rsp_drv <= 1'b1;
            end else if (rsp_cnt == 2)
                bus_din <= hi_b;
        end
    end

    always @(negedge CLK_50) begin
        int t, sg;
        logic e_busy, e_done, e_err, e_clk, e_cs, e_oe;
        logic [7:0]  e_dout;
        logic [15:0] e_res;
        if (chk_en) begin
            {e_busy, e_done, e_clk, e_cs, e_oe} = '0;
            e_dout = 8'd0;
            e_res  = m_result;
            if (m_active) begin
                t = cyc - m_t0;
                e_busy = 1'b1;
                if (t < LAT) begin
                    sg     = (t - 1) / H;
                    e_cs   = 1'b1;
                    e_clk  = (sg % 2) == 1;
                    e_oe   = sg < 2;
                    e_dout = e_oe ? 8'(CMDB + 32'(m_axis)) : 8'd0;
                end else begin
                    e_done = 1'b1;
                    e_res  = m_pend;
                end
            end
            e_err = cyc == m_err_at;
            chk("cycle_outputs",
                int'({busy, done, err, bus_clk, bus_cs, bus_oe, bus_dout, result}),
                int'({e_busy, e_done, e_err, e_clk, e_cs, e_oe, e_dout, e_res}));
            if (rsp_drv)
                chk("bus_conflict", int'(bus_oe), 0);
        end
    end

    task automatic wait_done(output int dc);
        int n = 0;
        while (!done && n < 200) begin
            @(negedge CLK_50);
            n++;
        end
        if (!done)
            chk("done_timeout", 0, 1);
        dc = cyc;
    endtask

    task automatic run_frame(input logic [1:0] ax, input logic [7:0] lo, input logic [7:0] hi,
                             output int s, output int dc);
        lo_b = lo;
        hi_b = hi;
        @(negedge CLK_50);
        start = 1'b1;
        axis  = ax;
        s     = cyc;
        @(negedge CLK_50);
        start = 1'b0;
        wait_done(dc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int s, dc, dc1, n0;
        rst = 1'b1; start = 1'b0; axis = 2'd0; lo_b = 8'd0; hi_b = 8'd0;
        repeat (3) @(negedge CLK_50);
        rst = 1'b0;
        @(negedge CLK_50);
        chk("reset_state", int'({busy, done, err, bus_clk, bus_cs, bus_oe, bus_dout, result}), 0);
        chk_en = 1'b1;

        // y axis: low 0x34, high 0x12
        n0 = n_rise;
        run_frame(2'd1, 8'h34, 8'h12, s, dc);
        chk("y_latency", dc - s, 29);
        chk("y_result", int'(result), 16'h1234);
        chk("y_cmd", int'(rsp_cmd), 121);
        chk("y_rises", n_rise - n0, 3);

        // illegal axis
        @(negedge CLK_50);
        start = 1'b1; axis = 2'd3;
        @(negedge CLK_50);
        start = 1'b0;
        chk("bad_err", int'(err), 1);
        chk("bad_bus", int'({bus_cs, bus_clk, bus_oe, busy}), 0);
        chk("bad_result", int'(result), 16'h1234);
        @(negedge CLK_50);
        chk("bad_err_pulse", int'(err), 0);

        // start held through a whole x frame
        lo_b = 8'h5A; hi_b = 8'hA5;
        @(negedge CLK_50);
        start = 1'b1; axis = 2'd0; s = cyc;
        wait_done(dc);
        chk("hold_latency", dc - s, 29);
        chk("hold_result", int'(result), 16'hA55A);
        chk("hold_cmd", int'(rsp_cmd), 120);
        @(negedge CLK_50);
        start = 1'b0;
        repeat (3) @(negedge CLK_50);
        chk("hold_single", int'(busy), 0);

        // reset ten cycles into a z frame, then a clean z frame
        lo_b = 8'h11; hi_b = 8'h22;
        @(negedge CLK_50);
        start = 1'b1; axis = 2'd2; s = cyc;
        @(negedge CLK_50);
        start = 1'b0;
        while (cyc < s + 10) @(negedge CLK_50);
        rst = 1'b1;
        @(negedge CLK_50);
        rst = 1'b0;
        chk("midrst_outputs", int'({busy, done, err, bus_clk, bus_cs, bus_oe, bus_dout, result}), 0);
        run_frame(2'd2, 8'h77, 8'h66, s, dc);
        chk("z_result", int'(result), 16'h6677);
        chk("z_cmd", int'(rsp_cmd), 122);

        // back-to-back x then z
        run_frame(2'd0, 8'hFF, 8'h00, s, dc1);
        chk("b2b_x_result", int'(result), 16'h00FF);
        lo_b = 8'h01; hi_b = 8'h80;
        @(negedge CLK_50);
        start = 1'b1; axis = 2'd2;
        @(negedge CLK_50);
        start = 1'b0;
        wait_done(dc);
        chk("b2b_z_result", int'(result), 16'h8001);
        chk("b2b_spacing", int'(dc - dc1 >= 7 * H + 2), 1);

        // start in the same cycle as reset is dropped
        @(negedge CLK_50);
        rst = 1'b1; start = 1'b1; axis = 2'd1;
        @(negedge CLK_50);
        rst = 1'b0; start = 1'b0;
        chk("rst_wins", int'({busy, bus_cs, result}), 0);
        repeat (3) @(negedge CLK_50);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
